// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: sequences the PLL reset, qualifies lock, and gates the
// downstream system reset on a stable lock. Re-runs the sequence on loss of lock.
// Ports:
//   clkin       board clock (also feeds the PLL); all logic on rising edge
//   reset       synchronous active-high reset
//   pll_lock    PLL lock indication, asynchronous to clkin
//   pll_reset   reset to the PLL
//   sys_reset   active-high reset for downstream clkin-domain logic
//   locked      high only while running on a qualified lock
//   lock_lost   one-cycle pulse when lock drops while running
//   retry_count saturating count of lock timeouts since reset
module pll_lock_supervisor #(
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT   = 65535,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned CNT_W          = 16
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic       sys_reset,
  output logic       locked,
  output logic       lock_lost,
  output logic [7:0] retry_count
);

  localparam int unsigned RETRY_W = 8;

  localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX    = '1;

  typedef enum logic [1:0] {
    RST_PLL,
    WAIT_LOCK,
    STABILIZE,
    RUNNING
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_d;
  logic               lock_meta, lock_s;
  logic               pll_reset_d, sys_reset_d, locked_d, lock_lost_d;

  // Two-flop synchronizer for the asynchronous lock input
  always_ff @(posedge clkin) begin
    if (reset) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
    end
  end

  // State, counter and registered outputs
  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q     <= RST_PLL;
      cnt_q       <= '0;
      pll_reset   <= 1'b1;
      sys_reset   <= 1'b1;
      locked      <= 1'b0;
      lock_lost   <= 1'b0;
      retry_count <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pll_reset   <= pll_reset_d;
      sys_reset   <= sys_reset_d;
      locked      <= locked_d;
      lock_lost   <= lock_lost_d;
      retry_count <= retry_d;
    end
  end

  // Next-state logic; outputs are decoded from the next state so they line up
  // with the state register after the edge.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    retry_d     = retry_count;
    lock_lost_d = 1'b0;

    case (state_q)
      RST_PLL: begin
        // Stale lock is ignored here; the PLL reset always runs to completion
        if (cnt_q == RST_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = STABILIZE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = RST_PLL;
          cnt_d   = '0;
          if (retry_count != RETRY_MAX) begin
            retry_d = retry_count + RETRY_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      STABILIZE: begin
        // A dropout during qualification just restarts the wait, no PLL reset
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = RUNNING;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RUNNING: begin
        if (!lock_s) begin
          state_d     = RST_PLL;
          cnt_d       = '0;
          lock_lost_d = 1'b1;
        end
      end

      default: begin
        state_d = RST_PLL;
        cnt_d   = '0;
      end
    endcase

    pll_reset_d = (state_d == RST_PLL);
    sys_reset_d = (state_d != RUNNING);
    locked_d    = (state_d == RUNNING);
  end

endmodule
